// File: rtl/bp_common_pkg.sv
// Shared dcache/LCE types and sizing macros for the LCE transmit path.
// Provides BSG_SAFE_CLOG2 and BP_LCE_CREDIT_WIDTH for the arbiter and the request handler.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

`ifndef BP_LCE_CREDIT_WIDTH
`define BP_LCE_CREDIT_WIDTH(credits_p) `BSG_SAFE_CLOG2((credits_p) + 1)
`endif

package bp_common_pkg;

  typedef enum logic [0:0] {
    e_ARB    = 1'b0,
    e_LOCKED = 1'b1
  } bp_lce_tx_arb_state_e;

endpackage

// File: rtl/bp_be_dcache_credit_counter.sv
// Up/down saturating LCE request credit counter with registered full/empty decode.
module bp_be_dcache_credit_counter
  #(parameter int credits_p = 8
  , localparam int credit_width_lp = `BP_LCE_CREDIT_WIDTH(credits_p)
  )
  (input  logic                       clk_i
  , input  logic                       reset_i
  , input  logic                       up_i
  , input  logic                       down_i
  , output logic [credit_width_lp-1:0] count_o
  , output logic                       full_o
  , output logic                       empty_o
  );

  localparam logic [credit_width_lp-1:0] max_lp = credit_width_lp'(credits_p);
  localparam logic [credit_width_lp-1:0] one_lp = credit_width_lp'(1);

  logic [credit_width_lp-1:0] count_r, count_n;

  // Flags come only from the register, so req_sent_i never reaches full_o combinationally.
  assign full_o  = (count_r == max_lp);
  assign empty_o = (count_r == '0);
  assign count_o = count_r;

  always_comb begin
    count_n = count_r;
    if (up_i && !down_i && !full_o)
      count_n = count_r + one_lp;
    else if (down_i && !up_i && !empty_o)
      count_n = count_r - one_lp;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) count_r <= '0;
    else          count_r <= count_n;
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(up_i && !down_i && full_o));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(down_i && !up_i && empty_o));
`endif

endmodule

// File: rtl/bp_be_dcache_lce_tx_arbiter.sv
// Round-robin, grant-locking arbiter for the dcache LCE->CCE response channel plus request credits.
// Optional BP_BE_DCACHE_TX_ARB_HIPRI0_EN: requester 0 always wins arbitration when valid.
module bp_be_dcache_lce_tx_arbiter
  import bp_common_pkg::*;
  #(parameter int num_req_p    = 3
  , parameter int resp_width_p = 64
  , parameter int credits_p    = 8
  , localparam int credit_width_lp = `BP_LCE_CREDIT_WIDTH(credits_p)
  , localparam int req_id_width_lp = `BSG_SAFE_CLOG2(num_req_p)
  )
  (input  logic                              clk_i
  , input  logic                              reset_i
  , input  logic [num_req_p-1:0]              resp_v_i
  , input  logic [num_req_p*resp_width_p-1:0] resp_data_i
  , output logic [num_req_p-1:0]              resp_yumi_o
  , output logic [resp_width_p-1:0]           lce_resp_o
  , output logic                              lce_resp_v_o
  , input  logic                              lce_resp_yumi_i
  , output logic [req_id_width_lp-1:0]        grant_id_o
  , input  logic                              req_sent_i
  , input  logic                              credit_return_i
  , output logic                              credits_full_o
  , output logic                              credits_empty_o
  , output logic [credit_width_lp-1:0]        credit_count_o
  );

`ifdef BP_BE_DCACHE_TX_ARB_HIPRI0_EN
  localparam bit hipri0_lp = 1'b1;
`else
  localparam bit hipri0_lp = 1'b0;
`endif

  typedef logic [req_id_width_lp-1:0] id_t;

  function automatic id_t next_ptr(input id_t g);
    return (int'(g) >= num_req_p-1) ? '0 : g + id_t'(1);
  endfunction

  logic [num_req_p-1:0][resp_width_p-1:0] resp_data_arr;
  assign resp_data_arr = resp_data_i;

  bp_lce_tx_arb_state_e state_r, state_n;
  id_t grant_r, grant_n, rr_ptr_r, rr_ptr_n;
  id_t rr_grant, arb_grant, grant, idx;
  logic rr_found, sel_v, yumi;

  // Rotating search from rr_ptr_r; with high priority enabled slot 0 is left to the override.
  always_comb begin
    rr_grant = rr_ptr_r;
    rr_found = 1'b0;
    idx      = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = id_t'((int'(rr_ptr_r) + i) % num_req_p);
      if (!rr_found && resp_v_i[idx] && !(hipri0_lp && idx == '0)) begin
        rr_found = 1'b1;
        rr_grant = idx;
      end
    end
    arb_grant = (hipri0_lp && resp_v_i[0]) ? '0 : rr_grant;
  end

  always_comb begin
    state_n     = state_r;
    grant_n     = grant_r;
    rr_ptr_n    = rr_ptr_r;
    grant       = arb_grant;
    sel_v       = |resp_v_i;
    resp_yumi_o = '0;
    if (state_r == e_LOCKED) begin
      grant = grant_r;
      sel_v = resp_v_i[grant_r];
    end
    sel_v = sel_v & reset_i;
    yumi  = sel_v & lce_resp_yumi_i;
    if (yumi) resp_yumi_o[grant] = 1'b1;

    case (state_r)
      e_ARB: begin
        if (yumi) begin
          if (!(hipri0_lp && grant == '0)) rr_ptr_n = next_ptr(grant);
        end else if (sel_v) begin
          grant_n = grant;
          state_n = e_LOCKED;
        end
      end
      e_LOCKED: begin
        if (yumi) begin
          if (!(hipri0_lp && grant_r == '0)) rr_ptr_n = next_ptr(grant_r);
          state_n = e_ARB;
        end else if (!resp_v_i[grant_r]) begin
          // Requester withdrew without a handshake; recover rather than wedge the channel.
          state_n = e_ARB;
        end
      end
      default: state_n = e_ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r  <= e_ARB;
      grant_r  <= '0;
      rr_ptr_r <= '0;
    end else begin
      state_r  <= state_n;
      grant_r  <= grant_n;
      rr_ptr_r <= rr_ptr_n;
    end
  end

  assign lce_resp_v_o = sel_v;
  assign lce_resp_o   = sel_v ? resp_data_arr[grant] : '0;
  assign grant_id_o   = reset_i ? grant : '0;

  bp_be_dcache_credit_counter #(.credits_p(credits_p)) credit_cnt
    (.clk_i   (clk_i)
    ,.reset_i (reset_i)
    ,.up_i    (req_sent_i)
    ,.down_i  (credit_return_i)
    ,.count_o (credit_count_o)
    ,.full_o  (credits_full_o)
    ,.empty_o (credits_empty_o)
    );

`ifndef SYNTHESIS
  a_lock_held: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(state_r == e_LOCKED && !resp_v_i[grant_r]));
  a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
    !(lce_resp_yumi_i && !lce_resp_v_o));
`endif

endmodule

// File: tb/tb_bp_be_dcache_lce_tx_arbiter.sv
// Directed bench for the LCE tx arbiter: round robin, locking, credits, async reset, priority option.
module tb_bp_be_dcache_lce_tx_arbiter;
  localparam int N  = 3;
  localparam int W  = 64;
  localparam int C  = 8;
  localparam int CW = 4;
  localparam int IW = 2;

`ifdef BP_BE_DCACHE_TX_ARB_HIPRI0_EN
  localparam int FIRST_G = 0;
`else
  localparam int FIRST_G = 2;
`endif
  localparam int SECOND_G = 2 - FIRST_G;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N-1:0]    resp_v;
  logic [N-1:0][W-1:0] data;
  logic [N*W-1:0]  resp_data;
  logic [N-1:0]    resp_yumi;
  logic [W-1:0]    lce_resp;
  logic            lce_resp_v;
  logic            lce_yumi;
  logic [IW-1:0]   grant_id;
  logic            req_sent, credit_ret;
  logic            full, empty;
  logic [CW-1:0]   count;
  logic [N-1:0]    exp_yumi;

  int checks = 0;
  int failures = 0;

  assign resp_data = data;

  bp_be_dcache_lce_tx_arbiter #(.num_req_p(N), .resp_width_p(W), .credits_p(C)) dut
    (.clk_i(clk), .reset_i(reset_n), .resp_v_i(resp_v), .resp_data_i(resp_data)
    ,.resp_yumi_o(resp_yumi), .lce_resp_o(lce_resp), .lce_resp_v_o(lce_resp_v)
    ,.lce_resp_yumi_i(lce_yumi), .grant_id_o(grant_id), .req_sent_i(req_sent)
    ,.credit_return_i(credit_ret), .credits_full_o(full), .credits_empty_o(empty)
    ,.credit_count_o(count));

  task automatic test_reset();
    reset_n = 1'b0; resp_v = 3'b111; lce_yumi = 1'b0; req_sent = 1'b0; credit_ret = 1'b0;
    data[0] = 64'hA000_0000_0000_0000; data[1] = 64'hB000_0000_0000_0001; data[2] = 64'hC000_0000_0000_0002;
    #2;
    checks++; if (lce_resp_v !== 1'b0) begin failures++; $display("FAIL reset_v got=%0b want=0", lce_resp_v); end
    checks++; if (resp_yumi !== 3'b000) begin failures++; $display("FAIL reset_yumi got=%b want=000", resp_yumi); end
    checks++; if (lce_resp !== 64'h0) begin failures++; $display("FAIL reset_data got=%h want=0", lce_resp); end
    checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL reset_grant got=%0d want=0", grant_id); end
    checks++; if (full !== 1'b0 || empty !== 1'b1 || count !== 4'd0) begin
      failures++; $display("FAIL reset_credits got full=%0b empty=%0b count=%0d want 0/1/0", full, empty, count); end
    @(negedge clk); resp_v = '0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); resp_v = 3'b111; lce_yumi = 1'b1;
      #1;
      exp_yumi = '0; exp_yumi[c % 3] = 1'b1;
      checks++; if (grant_id !== IW'(c % 3) || resp_yumi !== exp_yumi || lce_resp !== data[c % 3] || lce_resp_v !== 1'b1) begin
        failures++; $display("FAIL rr_cycle%0d got grant=%0d yumi=%b data=%h want grant=%0d yumi=%b", c, grant_id, resp_yumi, lce_resp, c % 3, exp_yumi); end
    end
    @(negedge clk); resp_v = '0; lce_yumi = 1'b0;
  endtask

  task automatic test_lock();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); resp_v = 3'b011; lce_yumi = 1'b0; data[1] = 64'hB100_0000_0000_0000 + 64'(c);
      #1;
      checks++; if (grant_id !== 2'd0 || lce_resp !== 64'hA000_0000_0000_0000 || lce_resp_v !== 1'b1 || resp_yumi !== 3'b000) begin
        failures++; $display("FAIL lock_hold%0d got grant=%0d data=%h v=%0b yumi=%b want grant=0 data=a000000000000000", c, grant_id, lce_resp, lce_resp_v, resp_yumi); end
    end
    @(negedge clk); lce_yumi = 1'b1; #1;
    checks++; if (resp_yumi !== 3'b001) begin failures++; $display("FAIL lock_yumi got=%b want=001", resp_yumi); end
    @(negedge clk); resp_v = 3'b010; lce_yumi = 1'b1; #1;
    checks++; if (grant_id !== 2'd1 || resp_yumi !== 3'b010 || lce_resp !== data[1]) begin
      failures++; $display("FAIL lock_next got grant=%0d yumi=%b want grant=1 yumi=010", grant_id, resp_yumi); end
    @(negedge clk); resp_v = '0; lce_yumi = 1'b0;
  endtask

  // rr pointer sits at 2 on entry.
  task automatic test_hipri0();
    @(negedge clk); resp_v = 3'b101; lce_yumi = 1'b1; #1;
    checks++; if (grant_id !== IW'(FIRST_G)) begin failures++; $display("FAIL prio_first got=%0d want=%0d", grant_id, FIRST_G); end
    @(negedge clk); resp_v = 3'b101; resp_v[FIRST_G] = 1'b0; #1;
    checks++; if (grant_id !== IW'(SECOND_G) || lce_resp !== data[SECOND_G]) begin
      failures++; $display("FAIL prio_second got=%0d want=%0d", grant_id, SECOND_G); end
    @(negedge clk); resp_v = '0; lce_yumi = 1'b0;
  endtask

  task automatic test_credits();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); req_sent = 1'b1;
      if (i == 7) begin
        #1;
        checks++; if (full !== 1'b0 || count !== 4'd7) begin
          failures++; $display("FAIL cred_pre_full got full=%0b count=%0d want 0/7", full, count); end
      end
    end
    @(negedge clk); req_sent = 1'b0; #1;
    checks++; if (count !== 4'd8 || full !== 1'b1 || empty !== 1'b0) begin
      failures++; $display("FAIL cred_full got count=%0d full=%0b empty=%0b want 8/1/0", count, full, empty); end
    @(negedge clk); req_sent = 1'b1; credit_ret = 1'b1;
    @(negedge clk); req_sent = 1'b0; credit_ret = 1'b0; #1;
    checks++; if (count !== 4'd8 || full !== 1'b1) begin
      failures++; $display("FAIL cred_both got count=%0d full=%0b want 8/1", count, full); end
    @(negedge clk); credit_ret = 1'b1;
    @(negedge clk); credit_ret = 1'b0; #1;
    checks++; if (count !== 4'd7 || full !== 1'b0) begin
      failures++; $display("FAIL cred_return got count=%0d full=%0b want 7/0", count, full); end
    @(negedge clk); credit_ret = 1'b1;
    @(negedge clk);
    @(negedge clk); credit_ret = 1'b0; #1;
    checks++; if (count !== 4'd5 || empty !== 1'b0) begin
      failures++; $display("FAIL cred_five got count=%0d empty=%0b want 5/0", count, empty); end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk); resp_v = 3'b011; lce_yumi = 1'b0;
    @(posedge clk); #3;
    checks++; if (lce_resp_v !== 1'b1 || count !== 4'd5) begin
      failures++; $display("FAIL midlock_pre got v=%0b count=%0d want 1/5", lce_resp_v, count); end
    reset_n = 1'b0; #1;
    checks++; if (lce_resp_v !== 1'b0 || resp_yumi !== 3'b000 || lce_resp !== 64'h0 || grant_id !== 2'd0) begin
      failures++; $display("FAIL midlock_outs got v=%0b yumi=%b data=%h grant=%0d want all zero", lce_resp_v, resp_yumi, lce_resp, grant_id); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || count !== 4'd0) begin
      failures++; $display("FAIL midlock_credits got empty=%0b full=%0b count=%0d want 1/0/0", empty, full, count); end
    resp_v = '0;
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk); resp_v = 3'b111; lce_yumi = 1'b1; #1;
    checks++; if (grant_id !== 2'd0 || resp_yumi !== 3'b001) begin
      failures++; $display("FAIL post_reset_g0 got grant=%0d yumi=%b want 0/001", grant_id, resp_yumi); end
    @(negedge clk); #1;
    checks++; if (grant_id !== 2'd1 || resp_yumi !== 3'b010) begin
      failures++; $display("FAIL post_reset_g1 got grant=%0d yumi=%b want 1/010", grant_id, resp_yumi); end
    @(negedge clk); resp_v = '0; lce_yumi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_hipri0();
    test_credits();
    test_reset_mid_lock();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
